// File: rtl/clk_drive_source_pkg.sv
// Shared types and constants for the clocked token source feeding the
// two-way split stage.
//   state_t    : token FSM states
//   SYNC_DEPTH : flops in the asynchronous-input synchroniser
package clk_drive_source_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRIVE     = 3'd1,
        WAIT_FREE = 3'd2,
        GAP       = 3'd3,
        FINISH    = 3'd4
    } state_t;

    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser plus rising-edge detector for an asynchronous handshake input.
// The output is a registered one-cycle pulse per rising edge of asyncIn.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   asyncIn   : asynchronous level input
//   risePulse : one-cycle pulse, clk domain
module sync_edge_det
    import clk_drive_source_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic risePulse
);

    logic [SYNC_DEPTH-1:0] syncQ;
    logic                  edgeQ;

    // Synchroniser chain, delayed copy, and registered edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ     <= '0;
            edgeQ     <= 1'b0;
            risePulse <= 1'b0;
        end else begin
            syncQ     <= {syncQ[SYNC_DEPTH-2:0], asyncIn};
            edgeQ     <= syncQ[SYNC_DEPTH-1];
            risePulse <= syncQ[SYNC_DEPTH-1] & ~edgeQ;
        end
    end

endmodule

// File: rtl/clk_drive_source.sv
// Clocked token source for the two-way split stage: issues a burst of drive
// pulses, one per token, each waiting for the split's free acknowledge.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_go, i_num : burst start strobe and token count (0 = empty burst)
//   i_abort     : end the burst once the in-flight token is freed
//   i_free      : asynchronous free acknowledge from the split
//   o_drive     : drive request, DRIVE_W cycles per token
//   o_busy      : burst in progress
//   o_done      : one-cycle end-of-burst pulse
//   o_timeout   : sticky free-timeout error
//   o_issued    : tokens driven in this burst
//   o_completed : frees received in this burst
module clk_drive_source
    import clk_drive_source_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DRIVE_W = 4,
    parameter int unsigned GAP_W   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic [CNT_W-1:0] i_num,
    input  logic             i_abort,
    input  logic             i_free,
    output logic             o_drive,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_issued,
    output logic [CNT_W-1:0] o_completed
);

    localparam int unsigned DRV_CW = (DRIVE_W > 1) ? $clog2(DRIVE_W) : 1;
    localparam int unsigned GAP_CW = (GAP_W > 1)   ? $clog2(GAP_W)   : 1;
    localparam int unsigned TMO_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic [DRV_CW-1:0] driveCnt;
    logic [GAP_CW-1:0] gapCnt;
    logic [TMO_CW-1:0] tmoCnt;
    logic              abortLat;
    logic              freeEvt;
    logic              abortNow_c;

    // An abort arriving in the deciding cycle counts as latched
    assign abortNow_c = abortLat | i_abort;

    sync_edge_det uFreeSync (
        .clk       (clk),
        .rst       (rst),
        .asyncIn   (i_free),
        .risePulse (freeEvt)
    );

    // Token FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            driveCnt    <= '0;
            gapCnt      <= '0;
            tmoCnt      <= '0;
            abortLat    <= 1'b0;
            o_drive     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_issued    <= '0;
            o_completed <= '0;
        end else begin
            o_done <= 1'b0;
            if (state != IDLE && i_abort) begin
                abortLat <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_go) begin
                        remaining   <= i_num;
                        o_completed <= '0;
                        if (i_num == '0) begin
                            o_issued <= '0;
                            o_done   <= 1'b1;
                        end else begin
                            state    <= DRIVE;
                            o_busy   <= 1'b1;
                            o_drive  <= 1'b1;
                            o_issued <= CNT_W'(1);
                            driveCnt <= '0;
                        end
                    end
                end

                DRIVE: begin
                    if (driveCnt == DRV_CW'(DRIVE_W - 1)) begin
                        state   <= WAIT_FREE;
                        o_drive <= 1'b0;
                        tmoCnt  <= '0;
                    end else begin
                        driveCnt <= driveCnt + DRV_CW'(1);
                    end
                end

                WAIT_FREE: begin
                    // A free in the timeout cycle takes priority
                    if (freeEvt) begin
                        remaining   <= remaining - CNT_W'(1);
                        o_completed <= o_completed + CNT_W'(1);
                        if (remaining == CNT_W'(1) || abortNow_c) begin
                            state  <= FINISH;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else if (GAP_W == 0) begin
                            state    <= DRIVE;
                            o_drive  <= 1'b1;
                            o_issued <= o_issued + CNT_W'(1);
                            driveCnt <= '0;
                        end else begin
                            state  <= GAP;
                            gapCnt <= '0;
                        end
                    end else if (tmoCnt == TMO_CW'(TIMEOUT - 1)) begin
                        state     <= FINISH;
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        tmoCnt <= tmoCnt + TMO_CW'(1);
                    end
                end

                GAP: begin
                    // The previous token is already freed, so abort ends here
                    if (abortNow_c) begin
                        state  <= FINISH;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (gapCnt == GAP_CW'(GAP_W - 1)) begin
                        state    <= DRIVE;
                        o_drive  <= 1'b1;
                        o_issued <= o_issued + CNT_W'(1);
                        driveCnt <= '0;
                    end else begin
                        gapCnt <= gapCnt + GAP_CW'(1);
                    end
                end

                FINISH: begin
                    state    <= IDLE;
                    abortLat <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_drive_source.sv
// Self-checking bench for clk_drive_source. A split-stage stub returns a free
// pulse after each drive; burst outcomes and handshake latencies are predicted
// from the token rules and compared against the design.
module tb_clk_drive_source;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DRIVE_W = 4;
    localparam int unsigned GAP_W   = 2;
    localparam int unsigned TIMEOUT = 1024;
    localparam int SYNC_STAGES = 2;
    localparam int BUDGET = 3000;

    logic             clk;
    logic             rst;
    logic             i_go;
    logic [CNT_W-1:0] i_num;
    logic             i_abort;
    logic             i_free;
    logic             o_drive;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout;
    logic [CNT_W-1:0] o_issued;
    logic [CNT_W-1:0] o_completed;

    int nAsserts = 0;
    int nFail    = 0;
    bit expTmo   = 1'b0;

    clk_drive_source #(
        .CNT_W   (CNT_W),
        .DRIVE_W (DRIVE_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_go        (i_go),
        .i_num       (i_num),
        .i_abort     (i_abort),
        .i_free      (i_free),
        .o_drive     (o_drive),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_issued    (o_issued),
        .o_completed (o_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst with the split stub answering (or not) each drive.
    // abortTok > 0 raises i_abort on the rise of that token's drive.
    task automatic runBurst(input int n, input int abortTok, input bit freeOn,
                            input bit goWhileBusy, input string tag);
        int cyc, riseCyc, pulses, expRise, freeAt, freeEnd;
        int lastFreeCyc, lastFall, doneCyc, expTokens, expDone, busyBad;
        bit prevDrive, doneSeen;
        expTokens = (abortTok > 0 && abortTok < n) ? abortTok : n;
        if (!freeOn) expTokens = 1;
        expTmo   = expTmo | !freeOn;
        pulses   = 0; busyBad = 0; riseCyc = 0; lastFreeCyc = 0; lastFall = 0;
        doneCyc  = 0; doneSeen = 1'b0; prevDrive = 1'b0;
        freeAt   = 1 << 30; freeEnd = 0;
        i_go = 1'b1; i_num = CNT_W'(n);
        step();
        cyc = 1; expRise = 1;
        while (!doneSeen && cyc < BUDGET) begin
            i_go = 1'b0; i_abort = 1'b0;
            if (o_drive && !prevDrive) begin
                pulses++;
                check({tag, " drive rise cycle"}, 32'(cyc), 32'(expRise));
                riseCyc = cyc;
                if (abortTok > 0 && pulses == abortTok) i_abort = 1'b1;
                if (goWhileBusy && pulses == 1) begin
                    i_go = 1'b1; i_num = CNT_W'(7);
                end
            end
            if (!o_drive && prevDrive) begin
                check({tag, " drive width"}, 32'(cyc - riseCyc), 32'(DRIVE_W));
                lastFall = cyc;
                if (freeOn) begin
                    freeAt  = cyc + int'($urandom_range(0, 10));
                    freeEnd = freeAt + int'($urandom_range(2, 4));
                end
            end
            if (o_done) begin
                doneSeen = 1'b1; doneCyc = cyc;
            end else if (o_busy !== 1'b1) begin
                busyBad++;
            end
            if (cyc == freeAt) begin
                lastFreeCyc = cyc;
                expRise = cyc + SYNC_STAGES + 1 + int'(GAP_W) + 1;
            end
            i_free = (cyc >= freeAt && cyc < freeEnd);
            prevDrive = o_drive;
            if (!doneSeen) begin
                step();
                cyc++;
            end
        end
        i_free = 1'b0; i_go = 1'b0; i_abort = 1'b0;
        check({tag, " done seen"}, 32'(doneSeen), 32'd1);
        expDone = freeOn ? lastFreeCyc + SYNC_STAGES + 1 + 1 : lastFall + int'(TIMEOUT);
        check({tag, " done cycle"}, 32'(doneCyc), 32'(expDone));
        check({tag, " busy while running"}, 32'(busyBad), 32'd0);
        check({tag, " busy at done"}, 32'(o_busy), 32'd0);
        check({tag, " drive pulses"}, 32'(pulses), 32'(expTokens));
        check({tag, " issued"}, 32'(o_issued), 32'(expTokens));
        check({tag, " completed"}, 32'(o_completed), freeOn ? 32'(expTokens) : 32'd0);
        check({tag, " timeout flag"}, 32'(o_timeout), 32'(expTmo));
        step();
        check({tag, " done one cycle"}, 32'(o_done), 32'd0);
        check({tag, " idle busy"}, 32'(o_busy), 32'd0);
        check({tag, " idle drive"}, 32'(o_drive), 32'd0);
        step();
    endtask

    initial begin
        int doneCnt;
        rst = 1'b1; i_go = 1'b0; i_num = '0; i_abort = 1'b0; i_free = 1'b0;
        step(); step();
        check("reset outputs", {26'd0, o_drive, o_busy, o_done, o_timeout,
              (o_issued != '0), (o_completed != '0)}, 32'd0);
        rst = 1'b0;
        step();

        // Single token
        runBurst(1, 0, 1'b1, 1'b0, "single");

        // Empty burst
        i_go = 1'b1; i_num = '0;
        step();
        i_go = 1'b0;
        check("zero done", 32'(o_done), 32'd1);
        check("zero busy", 32'(o_busy), 32'd0);
        check("zero drive", 32'(o_drive), 32'd0);
        step();
        check("zero done one cycle", 32'(o_done), 32'd0);
        check("zero issued", 32'(o_issued), 32'd0);

        // Three-token burst, then randomized bursts
        runBurst(3, 0, 1'b1, 1'b0, "burst3");
        for (int b = 0; b < 4; b++) begin
            runBurst(int'($urandom_range(1, 5)), 0, 1'b1, 1'b0, "random");
        end

        // Abort during the second drive, with an ignored i_go while busy
        runBurst(5, 2, 1'b1, 1'b1, "abort");

        // Abort while idle has no effect on the next burst
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        step();
        runBurst(2, 0, 1'b1, 1'b0, "idle-abort");

        // Free never returned
        runBurst(2, 0, 1'b0, 1'b0, "timeout");

        // Sticky timeout survives a later burst
        runBurst(1, 0, 1'b1, 1'b0, "after-timeout");

        // Asynchronous reset while waiting for free
        i_go = 1'b1; i_num = CNT_W'(3);
        step();
        i_go = 1'b0;
        for (int k = 0; k < int'(DRIVE_W) + 2; k++) step();
        check("pre-reset busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset busy", 32'(o_busy), 32'd0);
        check("async reset issued", 32'(o_issued), 32'd0);
        check("async reset timeout", 32'(o_timeout), 32'd0);
        step();
        rst = 1'b0;
        step();
        doneCnt = 0;
        i_free = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_done) doneCnt++;
        end
        i_free = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_done || o_busy || o_drive) doneCnt++;
        end
        check("spurious free activity", 32'(doneCnt), 32'd0);
        check("spurious free completed", 32'(o_completed), 32'd0);
        check("spurious free issued", 32'(o_issued), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
